// File: rtl/car_sim_pkg.sv
// Shared encodings, default parameters and gear-acceptance rules for the
// power/gear manager slice.
package car_sim_pkg;

    typedef logic [1:0] power_state_t;
    typedef logic [3:0] gear_t;

    localparam power_state_t PS_OFF   = 2'd0;
    localparam power_state_t PS_ACC   = 2'd1;
    localparam power_state_t PS_CRANK = 2'd2;
    localparam power_state_t PS_RUN   = 2'd3;

    localparam gear_t GEAR_P = 4'd3;
    localparam gear_t GEAR_R = 4'd6;
    localparam gear_t GEAR_N = 4'd9;
    localparam gear_t GEAR_D = 4'd12;

    localparam int DEF_DEBOUNCE_TICKS = 4;
    localparam int DEF_CRANK_TICKS    = 8;
    localparam int DEF_AUTO_OFF_SEC   = 60;
    localparam int DEF_EMERG_SEC      = 3;
    localparam int DEF_SPEED_W        = 8;

    localparam int NUM_KEYS = 6;
    localparam int K_START  = 0;
    localparam int K_BRAKE  = 1;
    localparam int K_P      = 2;
    localparam int K_R      = 3;
    localparam int K_N      = 4;
    localparam int K_D      = 5;

    // Nothing is accepted while OFF; re-requesting the current gear is a silent accept.
    function automatic logic gear_request_ok(input gear_t req, input gear_t cur,
                                             input power_state_t state,
                                             input logic stopped, input logic brake);
        logic ok;
        if (state == PS_OFF) begin
            ok = 1'b0;
        end else if (req == cur) begin
            ok = 1'b1;
        end else begin
            case (req)
                GEAR_P:  ok = stopped;
                GEAR_R:  ok = stopped & brake;
                GEAR_N:  ok = 1'b1;
                GEAR_D:  ok = ((cur == GEAR_P) || (cur == GEAR_R)) ? brake : 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Tick-sampled key debouncer: the level flips after DEBOUNCE_TICKS consecutive
// differing samples, with a one-CLK rise pulse registered alongside it.
module key_debouncer
    import car_sim_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic CLK,
    input  logic global_safe_rst,
    input  logic tick_spd,
    input  logic key_raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          rise_r;

    // Count differing samples; any agreeing sample restarts the run.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            if (tick_spd) begin
                if (key_raw != level_r) begin
                    if (cnt_r >= CNT_LAST) begin
                        level_r <= key_raw;
                        rise_r  <= key_raw;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end else begin
                    cnt_r <= '0;
                end
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/power_gear_manager.sv
// Ignition power-state machine (OFF/ACC/CRANK/RUN) and gear selector driven
// by debounced key events; every output comes straight from a flop.
module power_gear_manager
    import car_sim_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int CRANK_TICKS    = DEF_CRANK_TICKS,
    parameter int AUTO_OFF_SEC   = DEF_AUTO_OFF_SEC,
    parameter int EMERG_SEC      = DEF_EMERG_SEC,
    parameter int SPEED_W        = DEF_SPEED_W
) (
    input  logic               CLK,
    input  logic               global_safe_rst,
    input  logic               tick_spd,
    input  logic               tick_1s,
    input  logic               key_start,
    input  logic               key_brake,
    input  logic               key_p,
    input  logic               key_r,
    input  logic               key_n,
    input  logic               key_d,
    input  logic [SPEED_W-1:0] speed,
    output logic [1:0]         power_state,
    output logic               engine_on,
    output logic               acc_on,
    output logic               crank_active,
    output logic [3:0]         gear,
    output logic               gear_reject
);

    localparam int ACC_W = $clog2(AUTO_OFF_SEC + 2);
    localparam int CRK_W = $clog2(CRANK_TICKS + 2);
    localparam int EMG_W = $clog2(EMERG_SEC + 2);
    localparam logic [ACC_W-1:0] ACC_LAST   = ACC_W'(AUTO_OFF_SEC - 1);
    localparam logic [CRK_W-1:0] CRANK_LAST = CRK_W'(CRANK_TICKS - 1);
    localparam logic [EMG_W-1:0] EMERG_LAST = EMG_W'(EMERG_SEC - 1);

    logic [NUM_KEYS-1:0] raw_s;
    logic [NUM_KEYS-1:0] lvl_s;
    logic [NUM_KEYS-1:0] rise_s;
    logic                unused_s;

    power_state_t     state_r, state_nxt_s;
    gear_t            gear_r, gear_eval_s, gear_nxt_s, req_gear_s;
    logic             reject_r, reject_nxt_s, req_valid_s;
    logic             engine_on_r, acc_on_r, crank_active_r;
    logic [ACC_W-1:0] acc_cnt_r, acc_cnt_nxt_s;
    logic [CRK_W-1:0] crank_cnt_r, crank_cnt_nxt_s;
    logic [EMG_W-1:0] emerg_cnt_r, emerg_cnt_nxt_s;
    logic             start_evt_s, start_lvl_s, brake_lvl_s;
    logic             stopped_s, can_crank_s, entering_s, off_entry_s;

    assign raw_s = {key_d, key_n, key_r, key_p, key_brake, key_start};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
            .CLK             (CLK),
            .global_safe_rst (global_safe_rst),
            .tick_spd        (tick_spd),
            .key_raw         (raw_s[i]),
            .level           (lvl_s[i]),
            .rise            (rise_s[i])
        );
    end

    assign unused_s    = ^{lvl_s[K_D:K_P], rise_s[K_BRAKE]};
    assign start_evt_s = rise_s[K_START];
    assign start_lvl_s = lvl_s[K_START];
    assign brake_lvl_s = lvl_s[K_BRAKE];
    assign stopped_s   = (speed == '0);
    assign can_crank_s = brake_lvl_s && (gear_r == GEAR_P);
    assign entering_s  = (state_nxt_s != state_r);
    assign off_entry_s = (state_nxt_s == PS_OFF) && (state_r != PS_OFF);

    // Next power state and per-state timers; timers are cleared on any state change.
    always_comb begin
        state_nxt_s     = state_r;
        acc_cnt_nxt_s   = acc_cnt_r;
        crank_cnt_nxt_s = crank_cnt_r;
        emerg_cnt_nxt_s = emerg_cnt_r;
        case (state_r)
            PS_OFF: begin
                if (start_evt_s) begin
                    state_nxt_s = can_crank_s ? PS_CRANK : PS_ACC;
                end else begin
                    state_nxt_s = PS_OFF;
                end
            end
            PS_ACC: begin
                if (start_evt_s) begin
                    state_nxt_s = can_crank_s ? PS_CRANK : PS_OFF;
                end else if ((AUTO_OFF_SEC > 0) && tick_1s) begin
                    if (acc_cnt_r >= ACC_LAST) begin
                        state_nxt_s = PS_OFF;
                    end else begin
                        acc_cnt_nxt_s = acc_cnt_r + 1'b1;
                    end
                end else begin
                    acc_cnt_nxt_s = acc_cnt_r;
                end
            end
            PS_CRANK: begin
                if (!brake_lvl_s) begin
                    state_nxt_s = PS_ACC;
                end else if (tick_spd) begin
                    if (crank_cnt_r >= CRANK_LAST) begin
                        state_nxt_s = PS_RUN;
                    end else begin
                        crank_cnt_nxt_s = crank_cnt_r + 1'b1;
                    end
                end else begin
                    crank_cnt_nxt_s = crank_cnt_r;
                end
            end
            PS_RUN: begin
                if (start_evt_s && stopped_s) begin
                    state_nxt_s = PS_OFF;
                end else if (start_lvl_s && !stopped_s) begin
                    if (tick_1s) begin
                        if (emerg_cnt_r >= EMERG_LAST) begin
                            state_nxt_s = PS_OFF;
                        end else begin
                            emerg_cnt_nxt_s = emerg_cnt_r + 1'b1;
                        end
                    end else begin
                        emerg_cnt_nxt_s = emerg_cnt_r;
                    end
                end else begin
                    emerg_cnt_nxt_s = '0;
                end
            end
            default: state_nxt_s = PS_OFF;
        endcase
    end

    // Highest-priority gear edge this CLK, judged against the pre-transition state.
    always_comb begin
        req_valid_s  = 1'b1;
        req_gear_s   = gear_r;
        gear_eval_s  = gear_r;
        reject_nxt_s = 1'b0;
        if (rise_s[K_P]) begin
            req_gear_s = GEAR_P;
        end else if (rise_s[K_R]) begin
            req_gear_s = GEAR_R;
        end else if (rise_s[K_N]) begin
            req_gear_s = GEAR_N;
        end else if (rise_s[K_D]) begin
            req_gear_s = GEAR_D;
        end else begin
            req_valid_s = 1'b0;
        end
        if (req_valid_s) begin
            if (gear_request_ok(req_gear_s, gear_r, state_r, stopped_s, brake_lvl_s)) begin
                gear_eval_s = req_gear_s;
            end else begin
                reject_nxt_s = 1'b1;
            end
        end else begin
            gear_eval_s = gear_r;
        end
    end

    assign gear_nxt_s = off_entry_s ? GEAR_P : gear_eval_s;

    // State, gear and decoded outputs, all registered.
    always_ff @(posedge CLK or posedge global_safe_rst) begin
        if (global_safe_rst) begin
            state_r        <= PS_OFF;
            gear_r         <= GEAR_P;
            reject_r       <= 1'b0;
            engine_on_r    <= 1'b0;
            acc_on_r       <= 1'b0;
            crank_active_r <= 1'b0;
            acc_cnt_r      <= '0;
            crank_cnt_r    <= '0;
            emerg_cnt_r    <= '0;
        end else begin
            state_r        <= state_nxt_s;
            gear_r         <= gear_nxt_s;
            reject_r       <= reject_nxt_s;
            engine_on_r    <= (state_nxt_s == PS_RUN);
            acc_on_r       <= (state_nxt_s != PS_OFF);
            crank_active_r <= (state_nxt_s == PS_CRANK);
            acc_cnt_r      <= entering_s ? '0 : acc_cnt_nxt_s;
            crank_cnt_r    <= entering_s ? '0 : crank_cnt_nxt_s;
            emerg_cnt_r    <= entering_s ? '0 : emerg_cnt_nxt_s;
        end
    end

    assign power_state  = state_r;
    assign gear         = gear_r;
    assign gear_reject  = reject_r;
    assign engine_on    = engine_on_r;
    assign acc_on       = acc_on_r;
    assign crank_active = crank_active_r;

endmodule

// File: doc/power_gear_manager.md
POWER_GEAR_MANAGER -- requirements
Module: power_gear_manager

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive equal tick_spd samples needed to accept a key level.
REQ-002 SHALL have parameter CRANK_TICKS, default 8: tick_spd strobes spent in CRANK.
REQ-003 SHALL have parameter AUTO_OFF_SEC, default 60: tick_1s count in ACC before auto-off; 0 disables auto-off.
REQ-004 SHALL have parameter EMERG_SEC, default 3: seconds start key must be held in RUN at nonzero speed to force OFF.
REQ-005 SHALL have parameter SPEED_W, default 8: speed width.
REQ-006 CLK  in  1  system clock; all state changes on its rising edge.
REQ-007 global_safe_rst  in  1  asynchronous, active-high reset.
REQ-008 tick_spd  in  1  one-CLK sample strobe.
REQ-009 tick_1s  in  1  one-CLK seconds strobe.
REQ-010 key_start, key_brake, key_p, key_r, key_n, key_d  in  1 each  raw key levels, high = pressed.
REQ-011 speed  in  SPEED_W  current vehicle speed.
REQ-012 power_state  out  2  OFF=0, ACC=1, CRANK=2, RUN=3.
REQ-013 engine_on  out  1  high only in RUN.
REQ-014 acc_on  out  1  high in ACC, CRANK and RUN.
REQ-015 crank_active  out  1  high only in CRANK.
REQ-016 gear  out  4  P=3, R=6, N=9, D=12.
REQ-017 gear_reject  out  1  one-CLK pulse when a gear request is refused.

Function
REQ-018 Each key SHALL be debounced: sampled on tick_spd; the debounced level SHALL change only after DEBOUNCE_TICKS consecutive samples differ from it.
REQ-019 A debounced 0->1 transition SHALL produce a one-CLK event in the same CLK the level updates.
REQ-020 The FSM SHALL respond to start_evt in the CLK after it; all outputs SHALL be registered.
REQ-021 OFF on start_evt: brake high and gear==P -> CRANK; otherwise -> ACC.
REQ-022 ACC on start_evt: brake high and gear==P -> CRANK; otherwise -> OFF.
REQ-023 ACC with AUTO_OFF_SEC>0 SHALL go to OFF after AUTO_OFF_SEC tick_1s with no start_evt; the counter clears on ACC entry.
REQ-024 CRANK SHALL go to RUN after CRANK_TICKS tick_spd; debounced brake low before that SHALL abort to ACC.
REQ-025 RUN on start_evt with speed==0 SHALL go to OFF; with speed!=0, start_evt SHALL be ignored.
REQ-026 RUN with debounced start held and speed!=0 for EMERG_SEC consecutive tick_1s SHALL go to OFF; release or speed==0 clears the count.
REQ-027 Entry into OFF SHALL force gear to P.
REQ-028 Gear requests SHALL be debounced key edges; simultaneous edges resolve by priority P>R>N>D; lower requests are dropped without reject.
REQ-029 P SHALL require speed==0.
REQ-030 R SHALL require speed==0 and brake.
REQ-031 D from P or R SHALL require brake.
REQ-032 N SHALL always be accepted outside OFF.
REQ-033 Any request in OFF SHALL be rejected.
REQ-034 A refused request SHALL leave gear unchanged and pulse gear_reject one CLK after the edge.
REQ-035 A request equal to the current gear SHALL be accepted silently.
REQ-036 A gear request and start_evt in the same CLK SHALL be evaluated against pre-transition state and gear.
REQ-037 Counters SHALL saturate and never wrap.

Reset
REQ-038 While global_safe_rst is high, asynchronously: power_state=OFF, gear=P, engine_on=acc_on=crank_active=gear_reject=0, debounced levels=0, all counters=0.
REQ-039 Reset mid-CRANK or mid-RUN SHALL abort to OFF with no event emitted on release.
REQ-040 Keys already held at reset release SHALL need DEBOUNCE_TICKS samples before producing an event.

Structure
REQ-041 Gear codes, power-state encodings and default parameter values SHALL live in the shared package car_sim_pkg.
REQ-042 Debouncing SHALL be a sub-module key_debouncer, instantiated once per key (6 instances).

Verification
REQ-043 OFF, gear P, brake held; press start 5 tick_spd -> CRANK; 8 tick_spd later -> RUN, engine_on=1.
REQ-044 OFF, no brake, start press -> ACC; idle 60 tick_1s -> OFF, acc_on=0.
REQ-045 RUN, speed=40, press R -> gear_reject pulse, gear stays 12; speed=0, brake held, press R -> gear=6.
REQ-046 RUN, speed=30, start held 3 tick_1s -> OFF, gear=3; held only 2 s then released -> stays RUN.
REQ-047 CRANK, brake released at tick 4 -> ACC, crank_active=0.
REQ-048 Key glitch of 3 tick_spd -> no event; global_safe_rst pulse during RUN -> all REQ-038 values on the next CLK.
